// File: rtl/serial_mem_pkg.sv
// Shared definitions for the serial memory slave.
// Holds the FSM state encoding and the default parameter values used by
// serial_mem_slave and its testbench.
package serial_mem_pkg;

  localparam int ADDR_W_DEF  = 3;
  localparam int DATA_W_DEF  = 8;
  localparam int LEN_W_DEF   = 2;
  localparam int TIMEOUT_DEF = 1024;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RW   = 3'd1,
    ST_ADDR = 3'd2,
    ST_LEN  = 3'd3,
    ST_DATA = 3'd4,
    ST_STOP = 3'd5
  } state_e;

endpackage

// File: rtl/serial_mem_scl_sync.sv
// Two-flop synchronisers for the asynchronous scl/sda pad inputs, plus a
// rising-edge detector on the synchronised scl.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   scl, sda_i   : asynchronous serial clock / data from the pad
//   sda_s        : synchronised sda
//   scl_rise     : one-clock pulse on a synchronised scl 0->1 transition
module scl_sync (
  input  logic clock,
  input  logic reset,
  input  logic scl,
  input  logic sda_i,
  output logic sda_s,
  output logic scl_rise
);

  logic scl_meta_q, scl_meta_d;
  logic scl_sync_q, scl_sync_d;
  logic scl_prev_q, scl_prev_d;
  logic sda_meta_q, sda_meta_d;
  logic sda_sync_q, sda_sync_d;

  always_comb begin
    scl_meta_d = scl;
    scl_sync_d = scl_meta_q;
    scl_prev_d = scl_sync_q;
    sda_meta_d = sda_i;
    sda_sync_d = sda_meta_q;
  end

  // Idle bus levels: scl low, sda high.
  always_ff @(posedge clock) begin
    if (reset) begin
      scl_meta_q <= 1'b0;
      scl_sync_q <= 1'b0;
      scl_prev_q <= 1'b0;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
    end else begin
      scl_meta_q <= scl_meta_d;
      scl_sync_q <= scl_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_meta_q <= sda_meta_d;
      sda_sync_q <= sda_sync_d;
    end
  end

  assign sda_s    = sda_sync_q;
  assign scl_rise = scl_sync_q & ~scl_prev_q;

endmodule

// File: rtl/serial_mem_slave.sv
// Serial memory slave: a framed bit-serial protocol (start, rw, address,
// burst length, data words, stop) clocked by scl rising edges, accessing a
// small flop-array memory. Reads shift words out LSB first on sda_o.
// Ports:
//   clock, reset  : system clock, synchronous active-high reset
//   scl, sda_i    : asynchronous serial clock / data from the master
//   sda_o, sda_oe : serial read data and pad output enable
//   busy          : frame in progress
//   frame_done    : one-clock pulse on a good stop bit
//   frame_err     : sticky, stop bit sampled low
//   timeout_err   : sticky, frame aborted for lack of scl edges
//
// state   | meaning
// IDLE    | waiting for a start bit (sda low on scl rise)
// RW      | sampling the direction bit (1 = read)
// ADDR    | shifting in the start address, MSB first
// LEN     | shifting in the burst length field, MSB first
// DATA    | moving data words, LSB first, one word per DATA_W edges
// STOP    | sampling the stop bit
module serial_mem_slave
  import serial_mem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic scl,
  input  logic sda_i,
  output logic sda_o,
  output logic sda_oe,
  output logic busy,
  output logic frame_done,
  output logic frame_err,
  output logic timeout_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int BIT_W = $clog2(ADDR_W + LEN_W + DATA_W + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT);

  logic sda_s, scl_rise;

  scl_sync u_sync (
    .clock    (clock),
    .reset    (reset),
    .scl      (scl),
    .sda_i    (sda_i),
    .sda_s    (sda_s),
    .scl_rise (scl_rise)
  );

  state_e              state_q, state_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                sda_o_q, sda_o_d;
  logic                sda_oe_q, sda_oe_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ferr_q, ferr_d;
  logic                terr_q, terr_d;
  logic                wr_pend_q, wr_pend_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic [ADDR_W-1:0]   addr_inc;
  logic [DATA_W-1:0]   rd_word, rd_next, wr_shift;
  logic                last_bit;

  always_comb begin
    state_d   = state_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    len_d     = len_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    sda_o_d   = sda_o_q;
    sda_oe_d  = sda_oe_q;
    done_d    = 1'b0;
    ferr_d    = ferr_q;
    terr_d    = terr_q;
    wr_pend_d = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    addr_inc  = addr_q + ADDR_W'(1);
    rd_word   = mem_q[addr_q];
    rd_next   = mem_q[addr_inc];
    wr_shift  = {sda_s, shift_q[DATA_W-1:1]};
    last_bit  = 1'b0;

    if (state_q == ST_IDLE || scl_rise) tmo_d = TMO_LOAD;
    else                                tmo_d = tmo_q - TMO_W'(1);

    if (state_q != ST_IDLE && !scl_rise && tmo_q == TMO_W'(1)) begin
      // Abort; a partial write word never reaches wr_pend, so it is dropped.
      state_d  = ST_IDLE;
      terr_d   = 1'b1;
      sda_oe_d = 1'b0;
      sda_o_d  = 1'b0;
      bit_d    = '0;
    end else if (scl_rise) begin
      case (state_q)
        ST_IDLE: begin
          if (!sda_s) begin
            state_d = ST_RW;
            bit_d   = '0;
            addr_d  = '0;
            len_d   = '0;
          end
        end
        ST_RW: begin
          rw_d    = sda_s;
          bit_d   = '0;
          state_d = ST_ADDR;
        end
        ST_ADDR: begin
          addr_d = (addr_q << 1) | ADDR_W'(sda_s);
          if (int'(bit_q) == ADDR_W - 1) begin
            bit_d   = '0;
            state_d = ST_LEN;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
        ST_LEN: begin
          len_d = (len_q << 1) | LEN_W'(sda_s);
          if (int'(bit_q) == LEN_W - 1) begin
            bit_d   = '0;
            state_d = ST_DATA;
            if (rw_q) begin
              shift_d  = rd_word;
              sda_o_d  = rd_word[0];
              sda_oe_d = 1'b1;
            end
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
        ST_DATA: begin
          last_bit = (int'(bit_q) == DATA_W - 1);
          if (rw_q) begin
            if (last_bit) begin
              shift_d = rd_next;
              sda_o_d = rd_next[0];
            end else begin
              shift_d = shift_q >> 1;
              sda_o_d = shift_q[1];
            end
          end else begin
            shift_d = wr_shift;
            if (last_bit) begin
              // Commit is deferred one clock so the memory sees whole words only.
              wr_pend_d = 1'b1;
              wr_addr_d = addr_q;
              wr_data_d = wr_shift;
            end
          end
          if (last_bit) begin
            bit_d  = '0;
            addr_d = addr_inc;
            if (len_q == '0) begin
              state_d  = ST_STOP;
              sda_oe_d = 1'b0;
              sda_o_d  = 1'b0;
            end else begin
              len_d = len_q - LEN_W'(1);
            end
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
        ST_STOP: begin
          if (sda_s) done_d = 1'b1;
          else       ferr_d = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      tmo_q     <= TMO_LOAD;
      sda_o_q   <= 1'b0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      terr_q    <= 1'b0;
      wr_pend_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      tmo_q     <= tmo_d;
      sda_o_q   <= sda_o_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
      terr_q    <= terr_d;
      wr_pend_q <= wr_pend_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      if (wr_pend_q) mem_q[wr_addr_q] <= wr_data_q;
    end
  end

  assign sda_o       = sda_o_q;
  assign sda_oe      = sda_oe_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign frame_err   = ferr_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_serial_mem_slave.sv
// Directed testbench for serial_mem_slave: write/read frames, burst wrap,
// bad stop bit, timeout abort and reset in the middle of a read.
module tb_serial_mem_slave;

  localparam int TIMEOUT = 1024;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic scl   = 1'b0;
  logic sda_i = 1'b1;
  logic sda_o, sda_oe, busy, frame_done, frame_err, timeout_err;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int done_cnt  = 0;

  serial_mem_slave #(
    .ADDR_W  (3),
    .DATA_W  (8),
    .LEN_W   (2),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .scl         (scl),
    .sda_i       (sda_i),
    .sda_o       (sda_o),
    .sda_oe      (sda_oe),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_err   (frame_err),
    .timeout_err (timeout_err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (frame_done === 1'b1) done_cnt <= done_cnt + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

  // One scl pulse carrying bit b; samples sda_o/sda_oe just before scl falls.
  task automatic pulse(input logic b, output logic s, output logic oe);
    @(negedge clock);
    sda_i = b;
    repeat (3) @(negedge clock);
    scl = 1'b1;
    repeat (6) @(negedge clock);
    s  = sda_o;
    oe = sda_oe;
    scl = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic header(input logic rw, input logic [2:0] a, input logic [1:0] l,
                        output logic s0, output logic oe0, output logic oe_early);
    logic s, oe;
    oe_early = 1'b0;
    pulse(1'b0, s, oe); oe_early |= oe;
    pulse(rw, s, oe);   oe_early |= oe;
    for (int i = 2; i >= 0; i--) begin
      pulse(a[i], s, oe); oe_early |= oe;
    end
    pulse(l[1], s, oe); oe_early |= oe;
    pulse(l[0], s0, oe0);
  endtask

  task automatic write_frame(input logic [2:0] a, input logic [1:0] l,
                             input logic [31:0] w, input logic stop);
    logic s, oe, e;
    header(1'b0, a, l, s, oe, e);
    for (int k = 0; k <= int'(l); k++)
      for (int b = 0; b < 8; b++) pulse(w[8*k+b], s, oe);
    pulse(stop, s, oe);
    repeat (2) @(negedge clock);
  endtask

  // oe_ok: sda_oe low through the header, high on every data sample, low after.
  task automatic read_frame(input logic [2:0] a, input logic [1:0] l,
                            output logic [31:0] w, output logic oe_ok);
    logic s, oe, e, bitv;
    w = '0;
    header(1'b1, a, l, bitv, oe, e);
    oe_ok = !e && oe;
    for (int k = 0; k <= int'(l); k++) begin
      w[8*k] = bitv;
      for (int b = 1; b < 8; b++) begin
        pulse(1'b0, s, oe);
        w[8*k+b] = s;
        oe_ok &= oe;
      end
      pulse(1'b0, s, oe);
      if (k < int'(l)) begin
        bitv = s;
        oe_ok &= oe;
      end else begin
        oe_ok &= !oe;
      end
    end
    pulse(1'b1, s, oe);
    oe_ok &= !oe;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    total_cnt++;
    if ({sda_o, sda_oe, busy} !== 3'b000) $display("FAIL reset_outputs: got %b want 000", {sda_o, sda_oe, busy});
    else pass_cnt++;
    total_cnt++;
    if ({frame_done, frame_err, timeout_err} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {frame_done, frame_err, timeout_err});
    else pass_cnt++;
  endtask

  task automatic test_write();
    int d0;
    d0 = done_cnt;
    write_frame(3'd3, 2'd0, 32'h0000_00A5, 1'b1);
    total_cnt++;
    if (done_cnt - d0 !== 1) $display("FAIL write_done_pulses: got %0d want 1", done_cnt - d0);
    else pass_cnt++;
    total_cnt++;
    if (frame_err !== 1'b0) $display("FAIL write_frame_err: got %b want 0", frame_err);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL write_busy_after: got %b want 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_read();
    logic [31:0] w;
    logic ok;
    int d0;
    d0 = done_cnt;
    read_frame(3'd3, 2'd0, w, ok);
    total_cnt++;
    if (w[7:0] !== 8'hA5) $display("FAIL read_data: got %h want a5", w[7:0]);
    else pass_cnt++;
    total_cnt++;
    if (ok !== 1'b1) $display("FAIL read_oe_window: got %b want 1", ok);
    else pass_cnt++;
    total_cnt++;
    if (done_cnt - d0 !== 1) $display("FAIL read_done_pulses: got %0d want 1", done_cnt - d0);
    else pass_cnt++;
  endtask

  task automatic test_burst_wrap();
    logic [31:0] w;
    logic ok;
    write_frame(3'd6, 2'd3, 32'h4433_2211, 1'b1);
    read_frame(3'd6, 2'd3, w, ok);
    total_cnt++;
    if (w !== 32'h4433_2211) $display("FAIL burst_read: got %h want 44332211", w);
    else pass_cnt++;
    total_cnt++;
    if (ok !== 1'b1) $display("FAIL burst_oe_window: got %b want 1", ok);
    else pass_cnt++;
    read_frame(3'd0, 2'd0, w, ok);
    total_cnt++;
    if (w[7:0] !== 8'h33) $display("FAIL wrap_mem0: got %h want 33", w[7:0]);
    else pass_cnt++;
    read_frame(3'd5, 2'd0, w, ok);
    total_cnt++;
    if (w[7:0] !== 8'h00) $display("FAIL untouched_mem5: got %h want 00", w[7:0]);
    else pass_cnt++;
  endtask

  task automatic test_bad_stop();
    logic [31:0] w;
    logic ok;
    int d0;
    d0 = done_cnt;
    write_frame(3'd2, 2'd0, 32'h0000_005C, 1'b0);
    total_cnt++;
    if (frame_err !== 1'b1) $display("FAIL badstop_frame_err: got %b want 1", frame_err);
    else pass_cnt++;
    total_cnt++;
    if (done_cnt - d0 !== 0) $display("FAIL badstop_done: got %0d want 0", done_cnt - d0);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL badstop_busy: got %b want 0", busy);
    else pass_cnt++;
    read_frame(3'd2, 2'd0, w, ok);
    total_cnt++;
    if (w[7:0] !== 8'h5C) $display("FAIL badstop_data: got %h want 5c", w[7:0]);
    else pass_cnt++;
    total_cnt++;
    if (frame_err !== 1'b1) $display("FAIL frame_err_sticky: got %b want 1", frame_err);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    logic [31:0] w;
    logic s, oe, e, ok;
    int n;
    header(1'b0, 3'd3, 2'd0, s, oe, e);
    for (int b = 0; b < 4; b++) pulse(1'b1, s, oe);
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL timeout_busy_midframe: got %b want 1", busy);
    else pass_cnt++;
    repeat (TIMEOUT - 40) @(negedge clock);
    total_cnt++;
    if ({busy, timeout_err} !== 2'b10) $display("FAIL timeout_early: got busy,err=%b want 10", {busy, timeout_err});
    else pass_cnt++;
    n = 0;
    while (timeout_err !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    total_cnt++;
    if (timeout_err !== 1'b1) $display("FAIL timeout_err: got %b want 1", timeout_err);
    else pass_cnt++;
    total_cnt++;
    if ({busy, sda_oe} !== 2'b00) $display("FAIL timeout_idle: got busy,oe=%b want 00", {busy, sda_oe});
    else pass_cnt++;
    read_frame(3'd3, 2'd0, w, ok);
    total_cnt++;
    if (w[7:0] !== 8'hA5) $display("FAIL timeout_word_kept: got %h want a5", w[7:0]);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] w;
    logic s, oe, e, ok;
    int d0;
    header(1'b1, 3'd7, 2'd0, s, oe, e);
    total_cnt++;
    if (oe !== 1'b1) $display("FAIL midread_oe_before: got %b want 1", oe);
    else pass_cnt++;
    pulse(1'b0, s, oe);
    pulse(1'b0, s, oe);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    total_cnt++;
    if ({sda_oe, busy} !== 2'b00) $display("FAIL midread_reset_oe_busy: got %b want 00", {sda_oe, busy});
    else pass_cnt++;
    reset = 1'b0;
    @(negedge clock);
    total_cnt++;
    if ({frame_err, timeout_err} !== 2'b00) $display("FAIL midread_reset_sticky: got %b want 00", {frame_err, timeout_err});
    else pass_cnt++;
    read_frame(3'd3, 2'd0, w, ok);
    total_cnt++;
    if (w[7:0] !== 8'h00) $display("FAIL mem_cleared_3: got %h want 00", w[7:0]);
    else pass_cnt++;
    read_frame(3'd7, 2'd0, w, ok);
    total_cnt++;
    if (w[7:0] !== 8'h00) $display("FAIL mem_cleared_7: got %h want 00", w[7:0]);
    else pass_cnt++;
    d0 = done_cnt;
    write_frame(3'd1, 2'd0, 32'h0000_003C, 1'b1);
    read_frame(3'd1, 2'd0, w, ok);
    total_cnt++;
    if (w[7:0] !== 8'h3C) $display("FAIL post_reset_rw: got %h want 3c", w[7:0]);
    else pass_cnt++;
    total_cnt++;
    if (done_cnt - d0 !== 2) $display("FAIL post_reset_done: got %0d want 2", done_cnt - d0);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_burst_wrap();
    test_bad_stop();
    test_timeout();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/serial_mem_slave.md
SERIAL_MEM_SLAVE -- requirements
Module: serial_mem_slave

Interface
REQ-001 Parameter ADDR_W, default 3, word-address width; memory depth 2**ADDR_W words.
REQ-002 Parameter DATA_W, default 8, word width in bits.
REQ-003 Parameter LEN_W, default 2, burst-length field width; burst = field+1 words.
REQ-004 Parameter TIMEOUT, default 1024, clocks without an scl rising edge before a frame aborts.
REQ-005 clock  in  1  system clock; all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 scl  in  1  asynchronous serial clock from the master.
REQ-008 sda_i  in  1  asynchronous serial data from the pad.
REQ-009 sda_o  out  1  serial read data to the pad.
REQ-010 sda_oe  out  1  pad output enable; the pad tristate is outside this block.
REQ-011 busy  out  1  high whenever state is not IDLE.
REQ-012 frame_done  out  1  one-clock pulse on a good stop bit.
REQ-013 frame_err  out  1  sticky; set when the stop bit is sampled 0.
REQ-014 timeout_err  out  1  sticky; set on timeout abort.

Function
REQ-015 scl and sda_i SHALL pass through 2-flop synchronisers; an scl rising edge (sre) SHALL be a sampled 0->1 transition, a one-clock event.
REQ-016 All protocol sampling of sda SHALL occur only on sre cycles, using the synchronised sda.
REQ-017 FSM states: IDLE, RW, ADDR, LEN, DATA, STOP.
REQ-018 IDLE: sre with sda=0 (start bit) -> RW; sre with sda=1 -> remain IDLE.
REQ-019 RW: on sre latch rw (1=read, 0=write) -> ADDR.
REQ-020 ADDR: ADDR_W sre's, MSB first, shifted into the address register -> LEN after the last bit.
REQ-021 LEN: LEN_W sre's, MSB first -> DATA; word counter = field value.
REQ-022 DATA write: DATA_W bits per word, LSB first, collected in a shift register; the memory word SHALL be written once, in the clock after the word's last bit, never bit-by-bit.
REQ-023 DATA read: on entering DATA, load mem[addr] into the shift register, assert sda_oe, drive bit 0; each sre advances to the next bit; after bit DATA_W-1 the next word is loaded and bit 0 driven. The master samples on the scl falling edge.
REQ-024 After each word, address SHALL increment modulo 2**ADDR_W (7 -> 0 at default); the word counter decrements; after the last word -> STOP.
REQ-025 sda_oe SHALL be high only in DATA with rw=1; it SHALL drop in the clock the FSM leaves DATA.
REQ-026 STOP: on sre, sda=1 -> pulse frame_done; sda=0 -> set frame_err; either case -> IDLE.
REQ-027 In any non-IDLE state, TIMEOUT consecutive clocks without sre SHALL set timeout_err, drop sda_oe and go to IDLE; a partially collected write word SHALL be discarded.
REQ-028 The timeout counter SHALL clear on every sre and in IDLE.
REQ-029 A write committing in the same clock as a read load cannot occur; one frame is one direction.

Reset
REQ-030 Reset SHALL put the FSM in IDLE and clear sda_o, sda_oe, busy, frame_done, frame_err, timeout_err, the address, shift and length registers, the counters and the synchronisers (to scl=0, sda=1).
REQ-031 Reset SHALL clear all memory words to 0.
REQ-032 Reset asserted mid-frame SHALL take priority: no memory write in that clock, and the next frame requires a fresh start bit.

Structure
REQ-033 The state encoding and the default widths SHALL live in the shared package serial_mem_pkg.
REQ-034 The synchroniser and edge detector SHALL be the sub-module scl_sync (outputs: sda_s, scl_rise).
REQ-035 The memory SHALL be a flop array inside serial_mem_slave.

Verification
REQ-036 Write frame: start, rw=0, addr=3, len=0, data 0xA5, stop=1 -> mem[3]=0xA5, one frame_done pulse.
REQ-037 Read-back: start, rw=1, addr=3, len=0 -> sda_o bits 1,0,1,0,0,1,0,1 (LSB first); sda_oe high only during DATA.
REQ-038 Burst wrap: write addr=6, len=3, data 0x11,0x22,0x33,0x44 -> mem[6]=0x11, mem[7]=0x22, mem[0]=0x33, mem[1]=0x44.
REQ-039 Bad stop: write frame with stop bit 0 -> frame_err=1, data still written, no frame_done, FSM in IDLE.
REQ-040 Timeout: scl stalls after 4 data bits for TIMEOUT clocks -> timeout_err=1, target word unchanged, busy=0.
REQ-041 Reset mid-read -> sda_oe=0 the next clock, memory cleared, next valid frame works normally.
